pipe_stage_reg: RTL

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_pkg.sv | 21 ++
 rtl/pipe_stage_reg_sat_counter.sv | 26 ++
 rtl/pipe_stage_reg.sv | 101 ++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline constants: default stage-register widths and
// the EX/MEM payload field layout (control bits in the MSBs).
package pipe_pkg;

   localparam int DATA_W_DEF = 73;
   localparam int CTRL_W_DEF = 4;
   localparam int CNT_W_DEF  = 16;

   // EX/MEM payload: {RegWrite,MemtoReg,MemRead,MemWrite,ALUResult,RS2data,RD}
   localparam int EXMEM_RD_LSB   = 0;
   localparam int EXMEM_RD_W     = 5;
   localparam int EXMEM_RS2_LSB  = 5;
   localparam int EXMEM_RS2_W    = 32;
   localparam int EXMEM_ALU_LSB  = 37;
   localparam int EXMEM_ALU_W    = 32;
   localparam int EXMEM_MEMWRITE = 69;
   localparam int EXMEM_MEMREAD  = 70;
   localparam int EXMEM_MEMTOREG = 71;
   localparam int EXMEM_REGWRITE = 72;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter used for the stage stall statistic.
// Holds at all-ones instead of wrapping.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             inc_i,
   output logic [CNT_W-1:0] count_o
);

   logic [CNT_W-1:0] r_count;
   logic             w_full;

   assign w_full  = &r_count;
   assign count_o = r_count;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_count <= '0;
      end else if (inc_i && !w_full) begin
         r_count <= r_count + 1'b1;
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with flush and stall counter.
// Define PIPE_STAGE_SKID_EN for a 2-entry skid buffer with registered ready.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int CTRL_W = CTRL_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [DATA_W-1:0] in_data_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DATA_W-1:0] out_data_o,
   output logic [CNT_W-1:0]  stall_cnt_o
);

   localparam logic [DATA_W-1:0] CTRL_MASK =
      ~({DATA_W{1'b1}} >> CTRL_W);

   logic              r_valid;
   logic [DATA_W-1:0] r_data;
   logic              w_in_xfer;
   logic              w_out_xfer;
   logic              w_stall;

   assign w_in_xfer  = in_valid_i & in_ready_o;
   assign w_out_xfer = r_valid & out_ready_i;
   assign w_stall    = r_valid & ~out_ready_i;

   // Bubbles must never carry live control bits downstream
   assign out_valid_o = r_valid;
   assign out_data_o  = r_valid ? r_data : (r_data & ~CTRL_MASK);

`ifdef PIPE_STAGE_SKID_EN
   logic              r_skid_valid;
   logic [DATA_W-1:0] r_skid_data;

   assign in_ready_o = ~r_skid_valid | flush_i;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_valid      <= 1'b0;
         r_data       <= '0;
         r_skid_valid <= 1'b0;
         r_skid_data  <= '0;
      end else if (flush_i) begin
         r_valid      <= 1'b0;
         r_skid_valid <= 1'b0;
      end else if (w_out_xfer) begin
         if (r_skid_valid) begin
            r_data       <= r_skid_data;
            r_skid_valid <= 1'b0;
         end else begin
            r_valid <= w_in_xfer;
            if (w_in_xfer) begin
               r_data <= in_data_i;
            end
         end
      end else if (w_in_xfer) begin
         if (!r_valid) begin
            r_valid <= 1'b1;
            r_data  <= in_data_i;
         end else begin
            r_skid_valid <= 1'b1;
            r_skid_data  <= in_data_i;
         end
      end
   end
`else
   assign in_ready_o = ~r_valid | out_ready_i | flush_i;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (flush_i) begin
         r_valid <= 1'b0;
      end else if (w_in_xfer) begin
         r_valid <= 1'b1;
         r_data  <= in_data_i;
      end else if (w_out_xfer) begin
         r_valid <= 1'b0;
      end
   end
`endif

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_stall_cnt (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .inc_i   (w_stall),
      .count_o (stall_cnt_o)
   );

endmodule
